// File: rtl/lock_ctrl_fsm_if.sv
// lock_ctrl_fsm_if: signal bundle between the keypad entry side and the lock
// controller.
//   master : entry block / stimulus side. It drives entry_done, entry_code
//            and change_pw, and observes the controller outputs.
//   slave  : lock controller side. It drives clear_entry, unlocked,
//            enb_count, led_cnt16, fail_cnt and alarm.
interface lock_ctrl_fsm_if;
  logic        entry_done;
  logic [15:0] entry_code;
  logic        change_pw;
  logic        clear_entry;
  logic        unlocked;
  logic        enb_count;
  logic [15:0] led_cnt16;
  logic [2:0]  fail_cnt;
  logic        alarm;

  modport master (
    output entry_done, entry_code, change_pw,
    input  clear_entry, unlocked, enb_count, led_cnt16, fail_cnt, alarm
  );

  modport slave (
    input  entry_done, entry_code, change_pw,
    output clear_entry, unlocked, enb_count, led_cnt16, fail_cnt, alarm
  );
endinterface

// File: rtl/lock_ctrl_fsm.sv
// lock_ctrl_fsm: central controller of the digital lock.
// Compares each completed 4-digit entry against the stored password. It
// unlocks the door for UNLOCK_SEC seconds and allows a password change in
// that window. After MAX_TRIES consecutive wrong codes it enters a timed
// lockout and drives a countdown to the 7-segment display.
// Ports:
//   clk_100hz : controller clock (TICKS_PER_SEC cycles per second)
//   reset     : asynchronous, active-high
//   bus       : lock_ctrl_fsm_if.slave
//               inputs  entry_done, entry_code, change_pw
//               outputs clear_entry, unlocked, enb_count, led_cnt16,
//                       fail_cnt, alarm
// Optional build macro LOCK_ALARM_EN: when it is defined, alarm blinks
// during lockout. When it is undefined, alarm is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a completed entry
// CHECK    | one cycle to compare the latched code with the stored one
// UNLOCKED | door released, timed; change_pw opens NEW_PW
// NEW_PW   | door released, timed; next entry becomes the password
// LOCKOUT  | too many failures, timed countdown shown on display
module lock_ctrl_fsm #(
  parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
  parameter int          MAX_TRIES     = 3,
  parameter int          LOCKOUT_SEC   = 30,
  parameter int          UNLOCK_SEC    = 5,
  parameter int          TICKS_PER_SEC = 100
) (
  input logic            clk_100hz,
  input logic            reset,
  lock_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    UNLOCKED,
    NEW_PW,
    LOCKOUT
  } state_t;

  localparam logic [7:0] TICK_MAX    = 8'(TICKS_PER_SEC - 1);
  localparam logic [6:0] SEC_UNLOCK  = 7'(UNLOCK_SEC);
  localparam logic [6:0] SEC_LOCKOUT = 7'(LOCKOUT_SEC);
  localparam logic [2:0] TRIES_MAX   = 3'(MAX_TRIES);

  state_t      state_q, state_d;
  logic [15:0] code_q, code_d;
  logic [15:0] stored_q, stored_d;
  logic [2:0]  fail_q, fail_d;
  logic [6:0]  sec_q, sec_d;
  logic [7:0]  tick_q, tick_d;
  logic        entry_prev;
  logic        entry_rise;
  logic        tick_wrap;
  logic        expire;
  logic        clear_q, clear_d;
  logic        unlocked_q, unlocked_d;
  logic        enb_q, enb_d;
  logic [15:0] led_q, led_d;
  logic [3:0]  bcd_tens, bcd_ones;

  assign entry_rise = bus.entry_done & ~entry_prev;
  assign tick_wrap  = (tick_q == TICK_MAX);
  // A timed state ends on the tick wrap of its last second.
  assign expire     = tick_wrap && (sec_q == 7'd1);

  always_ff @(posedge clk_100hz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      code_q     <= '0;
      stored_q   <= DEFAULT_CODE;
      fail_q     <= '0;
      sec_q      <= '0;
      tick_q     <= '0;
      entry_prev <= 1'b0;
      clear_q    <= 1'b0;
      unlocked_q <= 1'b0;
      enb_q      <= 1'b0;
      led_q      <= 16'hFFFF;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      stored_q   <= stored_d;
      fail_q     <= fail_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
      entry_prev <= bus.entry_done;
      clear_q    <= clear_d;
      unlocked_q <= unlocked_d;
      enb_q      <= enb_d;
      led_q      <= led_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    stored_d   = stored_q;
    fail_d     = fail_q;
    sec_d      = sec_q;
    tick_d     = tick_q;
    clear_d    = 1'b0;
    unlocked_d = unlocked_q;

    // One shared seconds timer serves all timed states. Each state entry
    // below overrides tick and sec with fresh values.
    if (state_q == UNLOCKED || state_q == NEW_PW || state_q == LOCKOUT) begin
      if (tick_wrap) begin
        tick_d = '0;
        sec_d  = sec_q - 7'd1;
      end else begin
        tick_d = tick_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (entry_rise) begin
          code_d  = bus.entry_code;
          state_d = CHECK;
        end
      end
      CHECK: begin
        clear_d = 1'b1;
        tick_d  = '0;
        if (code_q == stored_q) begin
          fail_d     = '0;
          sec_d      = SEC_UNLOCK;
          unlocked_d = 1'b1;
          state_d    = UNLOCKED;
        end else if ((fail_q + 3'd1) == TRIES_MAX) begin
          fail_d  = '0;
          sec_d   = SEC_LOCKOUT;
          state_d = LOCKOUT;
        end else begin
          fail_d  = fail_q + 3'd1;
          state_d = IDLE;
        end
      end
      UNLOCKED: begin
        // A change request in the expiry cycle still wins.
        if (bus.change_pw) begin
          sec_d   = SEC_UNLOCK;
          tick_d  = '0;
          state_d = NEW_PW;
        end else if (expire) begin
          unlocked_d = 1'b0;
          state_d    = IDLE;
        end
      end
      NEW_PW: begin
        if (entry_rise) begin
          stored_d   = bus.entry_code;
          clear_d    = 1'b1;
          unlocked_d = 1'b0;
          state_d    = IDLE;
        end else if (expire) begin
          unlocked_d = 1'b0;
          state_d    = IDLE;
        end
      end
      LOCKOUT: begin
        if (expire) begin
          clear_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Split sec_d into digits so that the registered display matches the
  // seconds register in the same cycle.
  always_comb begin
    bcd_tens = 4'(sec_d / 7'd10);
    bcd_ones = 4'(sec_d % 7'd10);
    enb_d    = (state_d == LOCKOUT);
    led_d    = enb_d ? {8'hFF, bcd_tens, bcd_ones} : 16'hFFFF;
  end

  assign bus.clear_entry = clear_q;
  assign bus.unlocked    = unlocked_q;
  assign bus.enb_count   = enb_q;
  assign bus.led_cnt16   = led_q;
  assign bus.fail_cnt    = fail_q;

`ifdef LOCK_ALARM_EN
  localparam logic [7:0] HALF_MAX = 8'(TICKS_PER_SEC / 2 - 1);

  logic [7:0] half_q;
  logic       alarm_q;

  // Blink at half-second intervals. The alarm is high for the first half
  // second of the lockout and goes low as soon as the lockout ends.
  always_ff @(posedge clk_100hz or posedge reset) begin
    if (reset) begin
      half_q  <= '0;
      alarm_q <= 1'b0;
    end else if (state_d == LOCKOUT && state_q != LOCKOUT) begin
      half_q  <= '0;
      alarm_q <= 1'b1;
    end else if (state_d == LOCKOUT) begin
      if (half_q == HALF_MAX) begin
        half_q  <= '0;
        alarm_q <= ~alarm_q;
      end else begin
        half_q  <= half_q + 8'd1;
      end
    end else begin
      half_q  <= '0;
      alarm_q <= 1'b0;
    end
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = 1'b0;
`endif

endmodule

// File: doc/lock_ctrl_fsm.md
Name: lock_ctrl_fsm

Overview:
- Central controller of the digital lock.
- Watches the 4-digit entry block's completion flag and compares the entered code against a stored password.
- Drives unlock and password-change sequencing, counts wrong attempts, and runs a timed lockout with a countdown for the 7-segment display.
- Clears the entry block after every decision so a new code can be typed.

Parameters:
- DEFAULT_CODE, 16'h1234: password loaded at reset, 4 BCD digits, MSB digit first.
- MAX_TRIES, 3: consecutive wrong entries that trigger lockout; range 1..7.
- LOCKOUT_SEC, 30: lockout duration in seconds; range 1..99.
- UNLOCK_SEC, 5: time unlocked stays high, also the password-change window; range 1..99.
- TICKS_PER_SEC, 100: clk_100hz cycles per second; range 2..255.

Ports:
- clk_100hz, input, 1: controller clock.
- reset, input, 1: asynchronous, active-high.
- entry_done, input, 1: entry block "4 digits entered" level flag; stays high until the entry block is cleared.
- entry_code, input, 16: entered code {d0,d1,d2,d3}; valid while entry_done=1.
- change_pw, input, 1: level request to set a new password; honoured only in UNLOCKED.
- clear_entry, output, 1: one-cycle pulse to the entry block's reset.
- unlocked, output, 1: door-release drive.
- enb_count, output, 1: high during lockout; display shows led_cnt16 instead of entry digits.
- led_cnt16, output, 16: countdown digits {4'hF,4'hF,tens,ones}; 4'hF means blank digit.
- fail_cnt, output, 3: current consecutive-failure count.
- alarm, output, 1: see Optional Feature.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; stored code reloads DEFAULT_CODE (password is volatile).
  - Outputs: unlocked=0, enb_count=0, led_cnt16=16'hFFFF, clear_entry=0, fail_cnt=0, alarm=0.
  - Second and tick counters go to 0; edge-detect register goes to 0.
- Edge detect: entry_prev <= entry_done every cycle; entry_rise = entry_done & ~entry_prev. Only IDLE and NEW_PW act on entry_rise; other states ignore it.
- IDLE:
  - On entry_rise, latch entry_code into code_q and go to CHECK.
- CHECK (exactly 1 cycle):
  - code_q == stored: fail_cnt <= 0; go to UNLOCKED; load sec=UNLOCK_SEC.
  - Mismatch with fail_cnt+1 == MAX_TRIES: fail_cnt <= 0; go to LOCKOUT; load sec=LOCKOUT_SEC.
  - Other mismatch: fail_cnt <= fail_cnt+1; go to IDLE.
  - Every exit pulses clear_entry in the first cycle of the next state.
  - Latency from entry_rise to unlocked=1 is 2 cycles.
- Timer, shared by UNLOCKED, NEW_PW and LOCKOUT:
  - tick counts 0..TICKS_PER_SEC-1; on wrap, sec decrements.
  - The state expires when tick wraps while sec==1, giving exactly sec*TICKS_PER_SEC cycles.
  - tick resets to 0 on every state entry.
- UNLOCKED:
  - unlocked=1.
  - change_pw=1 goes to NEW_PW and reloads sec=UNLOCK_SEC; unlocked stays 1.
  - On expiry, go to IDLE with unlocked=0.
  - change_pw sampled in the same cycle as expiry wins.
- NEW_PW:
  - On entry_rise: stored <= entry_code; pulse clear_entry; go to IDLE; unlocked=0.
  - On expiry: go to IDLE with no change to stored.
- LOCKOUT:
  - enb_count=1 and led_cnt16={4'hF,4'hF,sec/10,sec%10}, both registered.
  - Display shows LOCKOUT_SEC down to 01.
  - On expiry: enb_count=0, led_cnt16=16'hFFFF, pulse clear_entry, go to IDLE.
  - An entry_rise in the expiry cycle is ignored.
- clear_entry is never high for more than 1 consecutive cycle.
- Arithmetic:
  - sec is 7 bits, tick is 8 bits, fail_cnt is 3 bits; all are unsigned with no wrap, because their ranges are bounded by the parameters.
  - The BCD split is combinational from sec and registered into led_cnt16.
- Reset mid-lockout or mid-unlock aborts immediately with all outputs at reset values.

Optional Feature:
- Macro: LOCK_ALARM_EN.
- Defined: alarm toggles every TICKS_PER_SEC/2 cycles while in LOCKOUT, starting at 1 on entry; it returns to 0 on exit.
- Undefined: alarm is tied to 0 and no toggle logic is synthesized.

Test Plan:
- Bench parameter: TICKS_PER_SEC=4 for all scenarios.
- Correct code: reset; entry_code=16'h1234 with entry_done rising -> clear_entry pulse 1 cycle after CHECK; unlocked=1 two cycles after the rise; stays high 20 cycles (UNLOCK_SEC=5); fail_cnt=0.
- Wrong code once: entry 16'h1111 -> fail_cnt=1, unlocked=0, clear_entry pulse; correct code next -> fail_cnt=0, unlocked=1.
- Lockout: three entries of 16'h9999 -> enb_count=1; led_cnt16=16'hFF30 then 16'hFF29 after 4 cycles ... 16'hFF01; exit after 120 cycles; led_cnt16=16'hFFFF; an entry during lockout is ignored.
- Password change: unlock, hold change_pw, enter 16'h4321 -> stored updated; 16'h1234 now fails and 16'h4321 unlocks. NEW_PW timeout with no entry -> stored unchanged.
- Reset mid-LOCKOUT at sec=17 -> enb_count=0, led_cnt16=16'hFFFF, fail_cnt=0 immediately; stored returns to 16'h1234.
- With LOCK_ALARM_EN: alarm toggles every 2 cycles during lockout and is 0 otherwise. Without it: alarm is constantly 0.
